// File: rtl/rr_grant_scheduler_if.sv
// Handshake bundle between the requesting units and the round-robin grant scheduler.
// The master side is the requester pool; the slave side is the scheduler.
interface rr_grant_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic               done;
    logic               grant_valid;
    logic [NUM_REQ-1:0] grant_one_hot;
    logic [ID_W-1:0]    grant_id;
    logic               preempt;

    modport master (
        output request,
        output done,
        input  grant_valid,
        input  grant_one_hot,
        input  grant_id,
        input  preempt
    );

    modport slave (
        input  request,
        input  done,
        output grant_valid,
        output grant_one_hot,
        output grant_id,
        output preempt
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: registered one-hot grant held until done or hold-limit,
// back-to-back re-arbitration on release, integer grant index via one_hot_to_integer.
module one_hot_to_integer #(
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic [WIDTH-1:0] one_hot,
    output logic [ID_W-1:0]  index
);
    function automatic logic [WIDTH-1:0] bit_mask(input int b);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = ((i >> b) & 1) == 1;
        end
        return m;
    endfunction

    // Each index bit is the OR of the one-hot lines whose position has that bit set;
    // an all-zero input therefore encodes to 0.
    generate
        for (genvar gi = 0; gi < ID_W; gi++) begin : g_bit
            localparam logic [WIDTH-1:0] MASK = bit_mask(gi);
            assign index[gi] = |(one_hot & MASK);
        end
    endgenerate
endmodule

module rr_grant_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_grant_scheduler_if.slave  bus
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [ID_W-1:0]   LAST_RESET = ID_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t             state_reg,    state_next;
    logic [NUM_REQ-1:0] grant_reg,    grant_next;
    logic [ID_W-1:0]    last_reg,     last_next;
    logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic               preempt_reg,  preempt_next;

    logic               arb_valid;
    logic [ID_W-1:0]    arb_idx;
    logic [NUM_REQ-1:0] arb_one_hot;
    logic               limit_hit;
    int                 scan_idx;

    // Scan starts just past the last winner, so the previous holder is checked last
    // and can only win again when nobody else is requesting.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        scan_idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = int'(last_reg) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!arb_valid && bus.request[ID_W'(scan_idx)]) begin
                arb_valid = 1'b1;
                arb_idx   = ID_W'(scan_idx);
            end
        end
        arb_one_hot = NUM_REQ'(1) << arb_idx;
    end

    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_reg == HOLD_LAST);

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        last_next     = last_reg;
        hold_cnt_next = hold_cnt_reg;
        preempt_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    state_next    = GRANTED;
                    grant_next    = arb_one_hot;
                    last_next     = arb_idx;
                    hold_cnt_next = '0;
                end
            end
            GRANTED: begin
                if (bus.done || limit_hit) begin
                    // A release that coincides with done is a normal release, not a preemption.
                    preempt_next  = limit_hit && !bus.done;
                    hold_cnt_next = '0;
                    if (arb_valid) begin
                        grant_next = arb_one_hot;
                        last_next  = arb_idx;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else begin
                    hold_cnt_next = (MAX_HOLD != 0) ? hold_cnt_reg + HOLD_W'(1) : '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            last_reg     <= LAST_RESET;
            hold_cnt_reg <= '0;
            preempt_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            last_reg     <= last_next;
            hold_cnt_reg <= hold_cnt_next;
            preempt_reg  <= preempt_next;
        end
    end

    one_hot_to_integer #(
        .WIDTH (NUM_REQ),
        .ID_W  (ID_W)
    ) u_id_enc (
        .one_hot (grant_reg),
        .index   (bus.grant_id)
    );

    assign bus.grant_valid   = (state_reg == GRANTED);
    assign bus.grant_one_hot = grant_reg;
    assign bus.preempt       = preempt_reg;
endmodule
